// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Brief    : Instruction-port handshake between the fetch stage and the
//            memory controller (level request, single-cycle done strobe).
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              mc_if_done;
    logic [INST_W-1:0] mc_if_inst;

    modport master (
        output if_req,
        output if_addr,
        input  mc_if_done,
        input  mc_if_inst
    );

    modport slave (
        input  if_req,
        input  if_addr,
        output mc_if_done,
        output mc_if_inst
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : RV32I instruction-fetch stage: owns the PC, fetches through the
//            memory-controller instruction port, feeds the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                STALL_W  = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic [STALL_W-1:0] stall,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    if_fetch_if.master         mem,
    output logic               if_stall,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INST_W-1:0]  out_inst
);

    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                r_if_req;
    logic                w_if_req_nxt;
    logic [ADDR_W-1:0]   r_if_addr;
    logic [ADDR_W-1:0]   w_if_addr_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic [ADDR_W-1:0]   r_out_pc;
    logic [ADDR_W-1:0]   w_out_pc_nxt;
    logic [INST_W-1:0]   r_out_inst;
    logic [INST_W-1:0]   w_out_inst_nxt;
    logic                r_discard;
    logic                w_discard_nxt;
    logic [INST_W-1:0]   r_hold_inst;
    logic [INST_W-1:0]   w_hold_inst_nxt;
    logic [ADDR_W-1:0]   w_jump_pc;
    logic                w_unused;

    assign w_jump_pc = {jump_target[ADDR_W-1:2], 2'b00};

    // Stall bits above bit1 belong to later stages; target bits [1:0] are forced to zero.
    generate
        if (STALL_W > 2) begin : g_stall_wide
            assign w_unused = ^{stall[STALL_W-1:2], jump_target[1:0]};
        end else begin : g_stall_narrow
            assign w_unused = ^jump_target[1:0];
        end
    endgenerate

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_if_req_nxt    = r_if_req;
        w_if_addr_nxt   = r_if_addr;
        w_out_valid_nxt = 1'b0;
        w_out_pc_nxt    = r_out_pc;
        w_out_inst_nxt  = r_out_inst;
        w_discard_nxt   = r_discard;
        w_hold_inst_nxt = r_hold_inst;

        case (r_state)
            S_IDLE: begin
                if (jump_en) begin
                    w_pc_nxt = w_jump_pc;
                end else if (!stall[0]) begin
                    w_if_req_nxt  = 1'b1;
                    w_if_addr_nxt = r_pc;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mc_if_done) begin
                    w_if_req_nxt  = 1'b0;
                    w_discard_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                    if (jump_en) begin
                        w_pc_nxt = w_jump_pc;
                    end else if (!r_discard) begin
                        if (!stall[1]) begin
                            w_out_valid_nxt = 1'b1;
                            w_out_pc_nxt    = r_pc;
                            w_out_inst_nxt  = mem.mc_if_inst;
                            w_pc_nxt        = r_pc + c_pc_step;
                        end else begin
                            w_hold_inst_nxt = mem.mc_if_inst;
                            w_state_nxt     = S_HOLD;
                        end
                    end
                end else if (jump_en) begin
                    // The memory transaction cannot be cancelled: keep requesting, drop its data.
                    w_pc_nxt      = w_jump_pc;
                    w_discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (jump_en) begin
                    w_pc_nxt    = w_jump_pc;
                    w_state_nxt = S_IDLE;
                end else if (!stall[1]) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_pc_nxt    = r_pc;
                    w_out_inst_nxt  = r_hold_inst;
                    w_pc_nxt        = r_pc + c_pc_step;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_if_req    <= 1'b0;
            r_if_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
            r_discard   <= 1'b0;
            r_hold_inst <= '0;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_if_req    <= w_if_req_nxt;
            r_if_addr   <= w_if_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_discard   <= w_discard_nxt;
            r_hold_inst <= w_hold_inst_nxt;
        end
    end

    assign if_stall    = !(((r_state == S_WAIT) && mem.mc_if_done && !r_discard) ||
                           (r_state == S_HOLD));
    assign mem.if_req  = r_if_req;
    assign mem.if_addr = r_if_addr;
    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign out_inst    = r_out_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Self-checking bench for if_fetch: memory responder, program-order
//            reference model with scoreboard queue, directed and random phases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;
    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int STALL_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               rdy;
    logic [STALL_W-1:0] stall;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_target;
    logic               if_stall;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INST_W-1:0]  out_inst;

    if_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    if_fetch #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .STALL_W  (STALL_W),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .mem         (bus.master),
        .if_stall    (if_stall),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mem_img [logic [31:0]];

    // Reference state: next architectural fetch PC and the memory responder.
    logic [31:0] next_fetch = 32'h0;
    logic [31:0] busy_addr = 32'h0;
    bit          busy = 0;
    bit          orphan = 0;
    bit          stale = 0;
    bit          last_rdy = 0;
    bit          taken;
    int          cnt = 0;
    int          lat_min = 0;
    int          lat_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // Model update at each edge, then memory drive on the following falling edge.
    initial begin
        bus.mc_if_done = 1'b0;
        bus.mc_if_inst = '0;
        forever begin
            @(posedge clk);
            taken    = (bus.mc_if_done === 1'b1) && (rdy || rst);
            last_rdy = rdy && !rst;
            if (rst) begin
                exp_q.delete();
                stale      = 0;
                next_fetch = 32'h0;
                if (busy && !taken) orphan = 1;
            end else if (rdy) begin
                if (bus.mc_if_done && !orphan) begin
                    if (!jump_en && !stale) begin
                        exp_q.push_back({next_fetch, mem_rd(next_fetch)});
                        next_fetch = next_fetch + 32'd4;
                    end
                    stale = 0;
                end else if (jump_en && busy && !orphan) begin
                    stale = 1;
                end
                if (jump_en) begin
                    exp_q.delete();
                    next_fetch = {jump_target[31:2], 2'b00};
                end
            end
            if (taken) begin
                busy   = 0;
                orphan = 0;
            end

            @(negedge clk);
            if (!busy && bus.if_req === 1'b1) begin
                busy      = 1;
                busy_addr = bus.if_addr;
                cnt       = $urandom_range(lat_max, lat_min);
                chk("req_addr", bus.if_addr, next_fetch);
            end
            if (busy && cnt == 0) begin
                bus.mc_if_done = 1'b1;
                bus.mc_if_inst = mem_rd(busy_addr);
            end else begin
                bus.mc_if_done = 1'b0;
                bus.mc_if_inst = $urandom;
                if (busy) cnt--;
            end
        end
    end

    // Monitor: pops the scoreboard on each delivery and checks handshake outputs.
    initial begin
        logic [63:0] e;
        logic        exp_stall;
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b1) begin
                if (last_rdy && out_valid === 1'b1) begin
                    delivered++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got pc %h, expected no delivery", out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", out_pc, e[63:32]);
                        chk("out_inst", out_inst, e[31:0]);
                    end
                end
                exp_stall = !((exp_q.size() != 0) ||
                              (bus.mc_if_done && busy && !orphan && !stale));
                chk("if_stall", 32'(if_stall), 32'(exp_stall));
                if (busy && !orphan) begin
                    chk("req_held", 32'(bus.if_req), 32'd1);
                    chk("addr_stable", bus.if_addr, busy_addr);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_deliv(input int n, input int budget, input string name);
        int target;
        target = delivered + n;
        for (int i = 0; i < budget && delivered < target; i++) tick();
        chk(name, delivered, target);
    endtask

    task automatic wait_busy(input bit want, input int budget, input string name);
        for (int i = 0; i < budget && busy != want; i++) tick();
        chk(name, 32'(busy), 32'(want));
    endtask

    initial begin
        logic [31:0] saved_addr;
        int          start_deliv;
        rst = 1'b1; rdy = 1'b1; stall = '0; jump_en = 1'b0; jump_target = '0;
        mem_img[32'h0] = 32'h00000013;
        lat_min = 2; lat_max = 2;
        repeat (3) tick();
        chk("rst_if_req", 32'(bus.if_req), 32'd0);
        chk("rst_if_addr", bus.if_addr, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_if_stall", 32'(if_stall), 32'd1);
        rst = 1'b0;
        wait_deliv(1, 20, "first_fetch");

        // Back-to-back from a fresh reset with single-cycle memory.
        stall = 6'b000001;
        wait_busy(0, 20, "quiesce");
        rst = 1'b1; tick(); rst = 1'b0; stall = '0;
        lat_min = 0; lat_max = 0;
        wait_deliv(4, 30, "b2b_count");

        // Stall hold while data returns.
        mem_img[next_fetch] = 32'hDEADBEEF;
        lat_min = 1; lat_max = 1;
        wait_busy(1, 10, "hold_busy");
        stall = 6'b000011;
        repeat (3) tick();
        chk("hold_no_valid", 32'(out_valid), 32'd0);
        chk("hold_if_stall", 32'(if_stall), 32'd0);
        stall = '0;
        wait_deliv(1, 10, "hold_release");

        // Redirect while a fetch is in flight.
        lat_min = 3; lat_max = 3;
        wait_busy(1, 10, "redir_busy");
        jump_en = 1'b1; jump_target = 32'h100;
        tick();
        jump_en = 1'b0;
        chk("redir_req_held", 32'(bus.if_req), 32'd1);
        wait_deliv(1, 20, "redir_deliv");

        // Unaligned redirect in the same cycle as done.
        lat_min = 1; lat_max = 1;
        wait_busy(1, 10, "unal_busy");
        tick();
        jump_en = 1'b1; jump_target = 32'h203;
        tick();
        jump_en = 1'b0;
        chk("unal_no_valid", 32'(out_valid), 32'd0);
        chk("unal_req_drop", 32'(bus.if_req), 32'd0);
        wait_deliv(1, 20, "unal_deliv");

        // Freeze mid-request, then reset with the response still outstanding.
        lat_min = 8; lat_max = 8;
        wait_busy(1, 10, "frz_busy");
        saved_addr = bus.if_addr;
        rdy = 1'b0;
        repeat (5) tick();
        chk("frz_req", 32'(bus.if_req), 32'd1);
        chk("frz_addr", bus.if_addr, saved_addr);
        chk("frz_valid", 32'(out_valid), 32'd0);
        rst = 1'b1; stall = 6'b000001;
        tick();
        rst = 1'b0; rdy = 1'b1;
        chk("post_rst_addr", bus.if_addr, 32'h0);
        chk("post_rst_req", 32'(bus.if_req), 32'd0);
        wait_busy(0, 20, "late_done");
        tick();
        chk("late_done_ignored", 32'(out_valid), 32'd0);
        stall = '0;
        wait_deliv(1, 20, "post_rst_deliv");

        // Randomised traffic.
        start_deliv = delivered;
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rdy         = ($urandom_range(0, 9) != 0);
            stall       = STALL_W'($urandom);
            stall[0]    = ($urandom_range(0, 3) == 0);
            stall[1]    = ($urandom_range(0, 3) == 0);
            jump_en     = ($urandom_range(0, 15) == 0);
            jump_target = $urandom;
        end
        tick();
        rdy = 1'b1; jump_en = 1'b0; stall = 6'b000001;
        wait_busy(0, 20, "drain_busy");
        repeat (3) tick();
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_req", 32'(bus.if_req), 32'd0);
        chk("random_progress", 32'(delivered > start_deliv + 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
